event_feeder: RTL and testbench
===============================

# event_feeder

Front-end stage that turns two raw, asynchronous event lines into the single-cycle `En`/`Slt` strobes consumed by the dual 64-bit event counter directly downstream. Each line is synchronized and rising-edge detected, and each edge is queued in order in a small FIFO. Queued events are issued one per cycle, with downstream hold support. Events are never merged, and loss on overflow is reported.

## Interface
- `DEPTH`, default 4: FIFO entries; power of two, ≥2.
- `SYNC_STAGES`, default 2: synchronizer flops per event line; ≥2.
- `Clk`: input, 1 bit, rising-edge clock.
- `Reset`: input, 1 bit; reset `Reset`, synchronous, active-high; clock `Clk`.
- `Ev0`: input, 1 bit, raw asynchronous event line; each rising edge is one "type-0" event (Slt=0).
- `Ev1`: input, 1 bit, raw asynchronous event line; each rising edge is one "type-1" event (Slt=1).
- `Hold`: input, 1 bit, synchronous downstream pause; while high, no event is issued.
- `En`: output, 1 bit, registered; one-cycle strobe per issued event.
- `Slt`: output, 1 bit, registered; type of the issued event, valid when `En`=1.
- `Pending`: output, $clog2(DEPTH+1) bits, registered; current FIFO occupancy.
- `Overflow`: output, 1 bit, registered; sticky flag set when any event is dropped.

## Operation
- **Synchronizer:** each Ev line passes through `SYNC_STAGES` flops. The last stage is compared with a one-flop history register. Last stage 1 with history 0 gives a one-cycle edge pulse `e0`/`e1`.
- **FIFO:** `DEPTH` entries of 1 bit (event type), with read pointer, write pointer and count. Up to two writes and one read per cycle.
- **Push order:**
  - If `e0` and `e1` occur in the same cycle, type 0 is written first, then type 1.
  - The entry order always equals edge-detection order.
- **Free space:** `free = DEPTH − Pending + pop`. A same-cycle pop makes its slot available to that cycle's pushes.
- **Drop rules:**
  - Pushes are accepted in order while free > 0.
  - Any rejected push is discarded and sets `Overflow`=1.
  - With one free slot and both edges, type 0 is kept and type 1 is dropped.
- **Pop:** occurs when `Pending`>0 and `Hold`=0. That edge registers `En`=1 and `Slt`=head type, and advances the read pointer.
- **No pop:** `En`=0 and `Slt` holds its previous value.
- **Pointers:** wrap modulo `DEPTH`.
- **Pending update:** `Pending` next = `Pending` + accepted pushes − pop, and never exceeds `DEPTH`.
- **Overflow:** cleared only by `Reset`.
- **`Hold` semantics:** `Hold` never drops events; it only stalls the pop. Pushes continue while `Hold` is high.
- **Reset (on any Clk edge with `Reset`=1):**
  - Clears synchronizer flops, history flops, pointers, `Pending`, `En`, `Slt` and `Overflow`.
  - Any queued events are discarded.
  - An Ev line already high when `Reset` deasserts produces exactly one event, because history resets to 0.
- **Reset outputs:** `En`=0, `Slt`=0, `Pending`=0, `Overflow`=0.

## Timing
- Let edge 1 be the first Clk edge sampling Ev=1 (Ev low at edge 0).
- Edges 1..`SYNC_STAGES` fill the synchronizer. The FIFO write occurs at edge `SYNC_STAGES`+1, and `Pending` increments then.
- **Empty FIFO, `Hold`=0:** `En` is high in the cycle after edge `SYNC_STAGES`+2. With defaults that is after edge 4.
- **Throughput:** one issued event per cycle maximum. Two simultaneous edges issue on two consecutive cycles, type 0 first.
- **Hold:** `Hold` sampled at edge k suppresses `En` after edge k. Deasserting at edge k lets a pop occur at edge k+1.
- **Minimum pulse width:** Ev pulses shorter than one Clk period may be missed; this is permitted. Ev low time must be ≥1 period between counted edges.
- **Mid-operation reset:** the next edge after `Reset` is sampled high yields all reset values. `En` is never high in the cycle following a reset edge.

## Test plan
- **Single event:** reset, then raise `Ev0` at edge 0 with `Hold`=0 → `Pending`=1 after edge 3; `En`=1, `Slt`=0 for exactly one cycle after edge 4; `Pending`=0 afterward.
- **Simultaneous edges:** raise `Ev0` and `Ev1` in the same cycle → `Pending`=2; then En/Slt = (1,0) then (1,1) on consecutive cycles; `Overflow`=0.
- **Fill while held:** `Hold`=1, generate 5 alternating edges 0,1,0,1,0 with `DEPTH`=4 → `Pending`=4, `Overflow`=1, fifth event lost. Release `Hold` → Slt sequence 0,1,0,1 over four consecutive En cycles.
- **Boundary free slot:** `Pending`=3 with `Hold`=1, then both edges at once → `Pending`=4, type 1 dropped, `Overflow`=1. Repeat with `Hold`=0 and a pop in the same cycle → both accepted, `Overflow` stays 0.
- **Reset mid-operation:** `Pending`=3 and `Overflow`=1, then assert `Reset` one cycle → all outputs 0 and no `En` afterward. `Ev1` held high across reset release → exactly one (En=1, Slt=1).
- **Downstream integration:** 8 `Ev1` edges and 3 `Ev0` edges into the downstream counter → its type-0 count = 3 and its type-1 divide-by-4 count = 2.

Source files
------------

// File: rtl/event_feeder.sv
// Event front-end: synchronizes two raw event lines, detects rising edges and
// queues them in order, then issues one En/Slt strobe per cycle to the counter.
module event_feeder #(
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         Ev0,
  input  logic                         Ev1,
  input  logic                         Hold,
  output logic                         En,
  output logic                         Slt,
  output logic [$clog2(DEPTH+1)-1:0]   Pending,
  output logic                         Overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(DEPTH+1);
  localparam logic [PW:0] DEPTH_W = (PW+1)'(DEPTH);

  logic [SYNC_STAGES-1:0] r_sync0, r_sync1;
  logic                   r_hist0, r_hist1;
  logic [DEPTH-1:0]       r_mem;
  logic [AW-1:0]          r_wptr, r_rptr;
  logic [PW-1:0]          r_pending;
  logic                   r_en, r_slt, r_overflow;

  logic          w_e0, w_e1;
  logic          w_pop;
  logic [PW:0]   w_free;
  logic          w_acc0, w_acc1;
  logic [AW-1:0] w_wptr1;

  always_comb begin
    w_e0   = r_sync0[SYNC_STAGES-1] & ~r_hist0;
    w_e1   = r_sync1[SYNC_STAGES-1] & ~r_hist1;
    w_pop  = (r_pending != '0) && !Hold;
    // A same-cycle pop frees its slot for this cycle's pushes.
    w_free = DEPTH_W - {1'b0, r_pending} + {{PW{1'b0}}, w_pop};
    // Type 0 claims the first free slot; type 1 only gets one if a second is left.
    w_acc0  = w_e0 && (w_free != '0);
    w_acc1  = w_e1 && (w_free > {{PW{1'b0}}, w_acc0});
    w_wptr1 = r_wptr + AW'(w_acc0);
  end

  // NOTE: all sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, which the synchronizer chain depends on.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_sync0    <= '0;
      r_sync1    <= '0;
      r_hist0    <= 1'b0;
      r_hist1    <= 1'b0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_pending  <= '0;
      r_en       <= 1'b0;
      r_slt      <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_sync0 <= {r_sync0[SYNC_STAGES-2:0], Ev0};
      r_sync1 <= {r_sync1[SYNC_STAGES-2:0], Ev1};
      r_hist0 <= r_sync0[SYNC_STAGES-1];
      r_hist1 <= r_sync1[SYNC_STAGES-1];

      r_wptr    <= r_wptr + AW'(w_acc0) + AW'(w_acc1);
      r_pending <= r_pending + PW'(w_acc0) + PW'(w_acc1) - PW'(w_pop);

      if ((w_e0 && !w_acc0) || (w_e1 && !w_acc1))
        r_overflow <= 1'b1;

      r_en <= w_pop;
      if (w_pop) begin
        r_slt  <= r_mem[r_rptr];
        r_rptr <= r_rptr + AW'(1);
      end
    end
  end

  // NOTE: the FIFO storage has no reset; pointers and count define validity,
  // so stale entries are never read.
  always_ff @(posedge Clk) begin
    if (w_acc0) r_mem[r_wptr]  <= 1'b0;
    if (w_acc1) r_mem[w_wptr1] <= 1'b1;
  end

  assign En       = r_en;
  assign Slt      = r_slt;
  assign Pending  = r_pending;
  assign Overflow = r_overflow;

endmodule

// File: tb/tb_event_feeder.sv
// Scoreboard bench for event_feeder: stimulus pushes expected event types,
// a negedge monitor pops and compares on every En strobe.
module tb_event_feeder;

  logic       Clk = 1'b0;
  logic       Reset, Ev0, Ev1, Hold;
  logic       En, Slt, Overflow;
  logic [2:0] Pending;

  int n_tests = 0;
  int n_fail  = 0;
  bit q_exp[$];
  bit count_en = 1'b0;
  int cnt0 = 0, cnt1 = 0;

  event_feeder #(.DEPTH(4), .SYNC_STAGES(2)) dut (
    .Clk(Clk), .Reset(Reset), .Ev0(Ev0), .Ev1(Ev1), .Hold(Hold),
    .En(En), .Slt(Slt), .Pending(Pending), .Overflow(Overflow)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every issued event must match the head of the expected queue.
  always @(negedge Clk) begin
    if (En === 1'b1) begin
      if (q_exp.size() == 0) check("en_unexpected", 32'(En), 32'd0);
      else check("slt_order", 32'(Slt), 32'(q_exp.pop_front()));
      if (count_en) begin
        if (Slt) cnt1++;
        else     cnt0++;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    cyc(1);
    Reset = 1'b0;
    q_exp.delete();
  endtask

  task automatic pulse(input bit a, input bit b);
    Ev0 = a; Ev1 = b;
    cyc(1);
    Ev0 = 1'b0; Ev1 = 1'b0;
    cyc(1);
  endtask

  initial begin
    Reset = 1'b1; Ev0 = 1'b0; Ev1 = 1'b0; Hold = 1'b0;
    cyc(2);
    Reset = 1'b0;
    check("rst_en", 32'(En), 32'd0);
    check("rst_slt", 32'(Slt), 32'd0);
    check("rst_pending", 32'(Pending), 32'd0);
    check("rst_overflow", 32'(Overflow), 32'd0);

    // Single event: write at edge 3, En after edge 4.
    Ev0 = 1'b1; q_exp.push_back(1'b0);
    cyc(3);
    check("single_pending", 32'(Pending), 32'd1);
    check("single_en_early", 32'(En), 32'd0);
    cyc(1);
    check("single_en", 32'(En), 32'd1);
    check("single_pending0", 32'(Pending), 32'd0);
    Ev0 = 1'b0;
    cyc(1);
    check("single_en_once", 32'(En), 32'd0);
    cyc(3);

    // Simultaneous edges: type 0 then type 1 on consecutive cycles.
    Ev0 = 1'b1; Ev1 = 1'b1; q_exp.push_back(1'b0); q_exp.push_back(1'b1);
    cyc(3);
    check("simul_pending", 32'(Pending), 32'd2);
    cyc(1);
    check("simul_en0", 32'(En), 32'd1);
    cyc(1);
    check("simul_en1", 32'(En), 32'd1);
    Ev0 = 1'b0; Ev1 = 1'b0;
    cyc(1);
    check("simul_idle_en", 32'(En), 32'd0);
    check("simul_slt_hold", 32'(Slt), 32'd1);
    check("simul_overflow", 32'(Overflow), 32'd0);
    cyc(3);

    // Fill while held: fifth event lost.
    Hold = 1'b1;
    pulse(1, 0); q_exp.push_back(1'b0);
    pulse(0, 1); q_exp.push_back(1'b1);
    pulse(1, 0); q_exp.push_back(1'b0);
    pulse(0, 1); q_exp.push_back(1'b1);
    pulse(1, 0);
    cyc(3);
    check("fill_pending", 32'(Pending), 32'd4);
    check("fill_overflow", 32'(Overflow), 32'd1);
    check("fill_no_en", 32'(En), 32'd0);
    Hold = 1'b0;
    cyc(8);
    check("fill_drained", 32'(Pending), 32'd0);
    check("fill_ovf_sticky", 32'(Overflow), 32'd1);
    do_reset();
    check("ovf_cleared", 32'(Overflow), 32'd0);

    // Boundary: one free slot, both edges, held -> type 1 dropped.
    Hold = 1'b1;
    pulse(1, 0); q_exp.push_back(1'b0);
    pulse(0, 1); q_exp.push_back(1'b1);
    pulse(1, 0); q_exp.push_back(1'b0);
    cyc(3);
    check("bnd_pending3", 32'(Pending), 32'd3);
    pulse(1, 1); q_exp.push_back(1'b0);
    cyc(3);
    check("bnd_pending4", 32'(Pending), 32'd4);
    check("bnd_overflow", 32'(Overflow), 32'd1);
    Hold = 1'b0;
    cyc(8);
    check("bnd_drained", 32'(Pending), 32'd0);
    do_reset();

    // Boundary with same-cycle pop: both edges accepted.
    Hold = 1'b1;
    pulse(1, 0); q_exp.push_back(1'b0);
    pulse(0, 1); q_exp.push_back(1'b1);
    pulse(1, 0); q_exp.push_back(1'b0);
    cyc(3);
    Ev0 = 1'b1; Ev1 = 1'b1; q_exp.push_back(1'b0); q_exp.push_back(1'b1);
    cyc(2);
    check("pop_pre_pending", 32'(Pending), 32'd3);
    Hold = 1'b0;
    cyc(1);
    check("pop_pending4", 32'(Pending), 32'd4);
    check("pop_overflow", 32'(Overflow), 32'd0);
    check("pop_en", 32'(En), 32'd1);
    Ev0 = 1'b0; Ev1 = 1'b0;
    cyc(8);
    check("pop_drained", 32'(Pending), 32'd0);
    check("pop_ovf_final", 32'(Overflow), 32'd0);
    do_reset();

    // Reset mid-operation with Pending=3, Overflow=1.
    Hold = 1'b1;
    pulse(0, 1); q_exp.push_back(1'b1);
    pulse(1, 0);
    pulse(0, 1);
    pulse(1, 0);
    pulse(0, 1);
    cyc(3);
    check("mid_full", 32'(Pending), 32'd4);
    Hold = 1'b0;
    cyc(1);
    Hold = 1'b1;
    check("mid_pending3", 32'(Pending), 32'd3);
    check("mid_ovf", 32'(Overflow), 32'd1);
    check("mid_slt", 32'(Slt), 32'd1);
    Ev1 = 1'b1; Reset = 1'b1;
    cyc(1);
    check("mid_rst_en", 32'(En), 32'd0);
    check("mid_rst_slt", 32'(Slt), 32'd0);
    check("mid_rst_pending", 32'(Pending), 32'd0);
    check("mid_rst_ovf", 32'(Overflow), 32'd0);
    cyc(1);
    Reset = 1'b0; Hold = 1'b0;
    q_exp.delete();
    q_exp.push_back(1'b1);
    cyc(1);
    check("mid_no_en_after", 32'(En), 32'd0);
    cyc(6);
    check("mid_one_event", 32'(q_exp.size()), 32'd0);
    check("mid_pending_end", 32'(Pending), 32'd0);
    Ev1 = 1'b0;
    cyc(4);

    // Downstream integration: 8 type-1 and 3 type-0 events.
    count_en = 1'b1;
    for (int i = 0; i < 11; i++) begin
      bit t;
      t = (i % 3 == 2) ? 1'b0 : 1'b1;
      q_exp.push_back(t);
      pulse(!t, t);
    end
    cyc(6);
    count_en = 1'b0;
    check("ds_type0", 32'(cnt0), 32'd3);
    check("ds_type1_div4", 32'(cnt1 / 4), 32'd2);
    check("ds_overflow", 32'(Overflow), 32'd0);
    check("final_queue_empty", 32'(q_exp.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
